// File: rtl/pwm_capture.sv
// PWM capture: synchronises pwm_in and measures its period and high time in clk cycles.
// Optional deglitch filter after the synchroniser, enabled by defining PWM_DEGLITCH_EN.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic [7:0]       meas_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pwm_capture: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT must be in 1..2^CNT_W-1");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("pwm_capture: FILT_LEN must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   line;
  logic                   line_d_q, line_d_d;
  logic                   rise, fall;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_level_q, stuck_level_d;
  logic [7:0]       meas_count_q, meas_count_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEGLITCH_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Output follows s only after FILT_LEN consecutive samples at the new level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (s != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        filt_d = s;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign line = filt_q;
`else
  assign line = s;
`endif

  assign line_d_d = line;
  assign rise     = line & ~line_d_q;
  assign fall     = ~line & line_d_q;

  always_comb begin
    state_d       = state_q;
    hi_lat_d      = hi_lat_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    meas_valid_d  = 1'b0;
    timeout_d     = timeout_q;
    stuck_level_d = stuck_level_q;
    meas_count_d  = meas_count_q;

    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Edges are tested before the timeout so a coincident edge takes priority.
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          timeout_d = 1'b0;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          state_d  = ST_LOW;
        end else if (cnt_q >= CNT_TO) begin
          timeout_d     = 1'b1;
          stuck_level_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (rise) begin
          period_d     = cnt_q;
          high_time_d  = hi_lat_q;
          meas_valid_d = 1'b1;
          meas_count_d = meas_count_q + 8'd1;
          state_d      = ST_HIGH;
        end else if (cnt_q >= CNT_TO) begin
          timeout_d     = 1'b1;
          stuck_level_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      line_d_q      <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hi_lat_q      <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      stuck_level_q <= 1'b0;
      meas_count_q  <= '0;
    end else begin
      sync_q        <= sync_d;
      line_d_q      <= line_d_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_lat_q      <= hi_lat_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      meas_valid_q  <= meas_valid_d;
      timeout_q     <= timeout_d;
      stuck_level_q <= stuck_level_d;
      meas_count_q  <= meas_count_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign meas_valid  = meas_valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_level_q;
  assign meas_count  = meas_count_q;

endmodule
